// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with per-register busy scoreboard.
//   - Two combinational read ports (data + busy), one synchronous write port.
//   - A reserve port marks a register busy when a producer is issued; a write
//     clears it unless the same edge re-reserves the register.
//   - BUSY_CNT is a registered popcount of the busy bits, updated incrementally.
//   - Register 0 reads as zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read whose address matches an active write returns WD3 in the
//                same cycle and reports not-busy.
//   undefined -> reads come strictly from stored state.
module reg_file_sb #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    A1,
    input  logic [AW-1:0]    A2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             BUSY1,
    output logic             BUSY2,
    input  logic [AW-1:0]    A3,
    input  logic [WIDTH-1:0] WD3,
    input  logic             WE3,
    input  logic             RSV,
    input  logic [AW-1:0]    RA,
    output logic [AW:0]      BUSY_CNT
);

    localparam int NREG = 2 ** AW;

    // Architectural state
    logic [WIDTH-1:0] regs_reg [NREG];
    logic [NREG-1:0]  busy_reg;
    logic [NREG-1:0]  busy_next;
    logic [AW:0]      busy_cnt_reg;
    logic [AW:0]      busy_cnt_next;

    // Per-register one-hot decode of the write and reserve ports
    logic [NREG-1:0]  wr_hit;
    logic [NREG-1:0]  rsv_hit;

    // Port qualifiers: address 0 is a sink for both write and reserve
    logic wr_en;
    logic rsv_en;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_en  = WE3 && (A3 != '0);
    assign rsv_en = RSV && (RA != '0);

    // Decode and busy-bit next state per register. Reserve wins over write on
    // the same register because the reserving producer is younger.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wr_hit[gi]    = 1'b0;
                assign rsv_hit[gi]   = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_nonzero
                assign wr_hit[gi]    = wr_en  && (A3 == AW'(gi));
                assign rsv_hit[gi]   = rsv_en && (RA == AW'(gi));
                assign busy_next[gi] = rsv_hit[gi] | (busy_reg[gi] & ~wr_hit[gi]);
            end
        end
    endgenerate

    // Count only real transitions: a reserve of an idle register, or a write
    // that retires a busy register without being re-reserved on the same edge.
    assign cnt_inc = rsv_en && !busy_reg[RA];
    assign cnt_dec = wr_en && busy_reg[A3] && !(rsv_en && (RA == A3));

    // Incremental popcount update; simultaneous +1 and -1 cancel
    always_comb begin
        busy_cnt_next = busy_cnt_reg;
        if (cnt_inc && !cnt_dec) begin
            busy_cnt_next = busy_cnt_reg + {{AW{1'b0}}, 1'b1};
        end else if (cnt_dec && !cnt_inc) begin
            busy_cnt_next = busy_cnt_reg - {{AW{1'b0}}, 1'b1};
        end
    end

    // Register data storage; entry 0 is cleared by reset and never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_hit[i]) begin
                    regs_reg[i] <= WD3;
                end
            end
        end
    end

    // Scoreboard bits and busy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign BUSY_CNT = busy_cnt_reg;

`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding of the write port; the reader is older than any
    // producer reserved this cycle, so it sees the value as not busy.
    logic byp1;
    logic byp2;

    assign byp1 = wr_en && (A1 == A3);
    assign byp2 = wr_en && (A2 == A3);

    // Read port mux with write-back bypass
    always_comb begin
        RD1   = byp1 ? WD3 : regs_reg[A1];
        BUSY1 = byp1 ? 1'b0 : busy_reg[A1];
        RD2   = byp2 ? WD3 : regs_reg[A2];
        BUSY2 = byp2 ? 1'b0 : busy_reg[A2];
    end
`else
    // Read ports straight from stored state
    always_comb begin
        RD1   = regs_reg[A1];
        BUSY1 = busy_reg[A1];
        RD2   = regs_reg[A2];
        BUSY2 = busy_reg[A2];
    end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb.
// Handles both builds of the REGFILE_BYPASS_EN option.
module tb_reg_file_sb;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rst;
    logic [AW-1:0]    A1;
    logic [AW-1:0]    A2;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             BUSY1;
    logic             BUSY2;
    logic [AW-1:0]    A3;
    logic [WIDTH-1:0] WD3;
    logic             WE3;
    logic             RSV;
    logic [AW-1:0]    RA;
    logic [AW:0]      BUSY_CNT;

    int tests_run;
    int tests_failed;

    reg_file_sb #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .A1       (A1),
        .A2       (A2),
        .RD1      (RD1),
        .RD2      (RD2),
        .BUSY1    (BUSY1),
        .BUSY2    (BUSY2),
        .A3       (A3),
        .WD3      (WD3),
        .WE3      (WE3),
        .RSV      (RSV),
        .RA       (RA),
        .BUSY_CNT (BUSY_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance past the next rising edge; inputs are changed 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        A1 = '0; A2 = '0; A3 = '0; WD3 = '0; WE3 = 1'b0; RSV = 1'b0; RA = '0;

        // Reset state over every address
        #12;
        check("reset_cnt", 32'(BUSY_CNT), 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            A1 = AW'(a);
            A2 = AW'(31 - a);
            #1;
            check($sformatf("reset_rd1_%0d", a), RD1, 32'd0);
            check($sformatf("reset_rd2_%0d", 31 - a), RD2, 32'd0);
            check($sformatf("reset_busy_%0d", a), 32'({BUSY1, BUSY2}), 32'd0);
        end

        // Reserve 5, then write it back
        step();
        RSV = 1'b1; RA = 5'd5;
        step();
        RSV = 1'b0; A1 = 5'd5;
        #1;
        check("rsv5_busy1", 32'(BUSY1), 32'd1);
        check("rsv5_cnt", 32'(BUSY_CNT), 32'd1);
        check("rsv5_rd1", RD1, 32'd0);
        WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF;
        step();
        WE3 = 1'b0;
        #1;
        check("wr5_rd1", RD1, 32'hDEADBEEF);
        check("wr5_busy1", 32'(BUSY1), 32'd0);
        check("wr5_cnt", 32'(BUSY_CNT), 32'd0);

        // Same-cycle write/read of busy reg 7
        RSV = 1'b1; RA = 5'd7;
        step();
        RSV = 1'b0;
        WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h1234; A2 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp7_rd2_same", RD2, 32'h1234);
        check("byp7_busy2_same", 32'(BUSY2), 32'd0);
`else
        check("byp7_rd2_same", RD2, 32'd0);
        check("byp7_busy2_same", 32'(BUSY2), 32'd1);
`endif
        check("byp7_cnt_same", 32'(BUSY_CNT), 32'd1);
        step();
        WE3 = 1'b0;
        #1;
        check("wr7_rd2", RD2, 32'h1234);
        check("wr7_busy2", 32'(BUSY2), 32'd0);
        check("wr7_cnt", 32'(BUSY_CNT), 32'd0);

        // Write and re-reserve busy reg 9 on the same edge
        RSV = 1'b1; RA = 5'd9;
        step();
        A1 = 5'd9;
        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'hA5A50009;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("wr_rsv9_rd1_same", RD1, 32'hA5A50009);
        check("wr_rsv9_busy1_same", 32'(BUSY1), 32'd0);
`else
        check("wr_rsv9_rd1_same", RD1, 32'd0);
        check("wr_rsv9_busy1_same", 32'(BUSY1), 32'd1);
`endif
        check("wr_rsv9_cnt_before", 32'(BUSY_CNT), 32'd1);
        step();
        WE3 = 1'b0; RSV = 1'b0;
        #1;
        check("wr_rsv9_rd1", RD1, 32'hA5A50009);
        check("wr_rsv9_busy1", 32'(BUSY1), 32'd1);
        check("wr_rsv9_cnt", 32'(BUSY_CNT), 32'd1);
        // Retire 9 with a plain write
        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h00000099;
        step();
        WE3 = 1'b0;
        #1;
        check("ret9_busy1", 32'(BUSY1), 32'd0);
        check("ret9_cnt", 32'(BUSY_CNT), 32'd0);

        // Register 0 ignores write and reserve
        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; RSV = 1'b1; RA = 5'd0; A1 = 5'd0;
        #1;
        check("r0_rd1_same", RD1, 32'd0);
        check("r0_busy1_same", 32'(BUSY1), 32'd0);
        step();
        WE3 = 1'b0; RSV = 1'b0;
        #1;
        check("r0_rd1", RD1, 32'd0);
        check("r0_busy1", 32'(BUSY1), 32'd0);
        check("r0_cnt", 32'(BUSY_CNT), 32'd0);

        // Write to a non-busy register
        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h33333333;
        step();
        WE3 = 1'b0; A1 = 5'd3;
        #1;
        check("wr3_rd1", RD1, 32'h33333333);
        check("wr3_busy1", 32'(BUSY1), 32'd0);
        check("wr3_cnt", 32'(BUSY_CNT), 32'd0);

        // Double reserve of 4, then retire 4 while reserving 10
        RSV = 1'b1; RA = 5'd4;
        step();
        step();
        RSV = 1'b0;
        #1;
        check("dbl4_cnt", 32'(BUSY_CNT), 32'd1);
        RSV = 1'b1; RA = 5'd10; WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h44;
        step();
        RSV = 1'b0; WE3 = 1'b0; A1 = 5'd4; A2 = 5'd10;
        #1;
        check("swap_cnt", 32'(BUSY_CNT), 32'd1);
        check("swap_busy4", 32'(BUSY1), 32'd0);
        check("swap_busy10", 32'(BUSY2), 32'd1);
        check("swap_rd4", RD1, 32'h44);

        // Fill the scoreboard, then reset asynchronously mid-cycle
        RSV = 1'b1;
        for (int r = 1; r < 32; r++) begin
            RA = AW'(r);
            step();
        end
        RSV = 1'b0;
        #1;
        check("fill_cnt", 32'(BUSY_CNT), 32'd31);
        A1 = 5'd31; A2 = 5'd3;
        #1;
        check("fill_busy31", 32'(BUSY1), 32'd1);
        // Hold a reserve of 6 across the reset to confirm it is discarded
        RSV = 1'b1; RA = 5'd6;
        rst = 1'b1;
        #1;
        check("arst_cnt", 32'(BUSY_CNT), 32'd0);
        check("arst_busy31", 32'(BUSY1), 32'd0);
        check("arst_rd3", RD2, 32'd0);
        for (int a = 0; a < 32; a++) begin
            A1 = AW'(a);
            #1;
            check($sformatf("arst_busy_%0d", a), 32'(BUSY1), 32'd0);
        end
        step();
        A1 = 5'd6;
        #1;
        check("arst_edge_busy6", 32'(BUSY1), 32'd0);
        check("arst_edge_cnt", 32'(BUSY_CNT), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_busy6_pre", 32'(BUSY1), 32'd0);
        step();
        RSV = 1'b0;
        #1;
        check("rel_busy6", 32'(BUSY1), 32'd1);
        check("rel_cnt", 32'(BUSY_CNT), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with a per-register busy scoreboard for the pipelined core. It provides two asynchronous read ports and one synchronous write port, and it tracks in-flight producers so the hazard unit can stall on operands that are not yet written. An optional same-cycle write-to-read bypass serves the write-back stage. It replaces the fixed 32×32 register file in the datapath's decode stage.

## Interface
Parameters:
- `WIDTH`, 32, data width of every register.
- `AW`, 5, address width. Register count `NREG = 2**AW`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `A1`  in  AW  read address, port 1.
- `A2`  in  AW  read address, port 2.
- `RD1`  out  WIDTH  read data, port 1.
- `RD2`  out  WIDTH  read data, port 2.
- `BUSY1`  out  1  register `A1` has an outstanding producer.
- `BUSY2`  out  1  register `A2` has an outstanding producer.
- `A3`  in  AW  write address.
- `WD3`  in  WIDTH  write data.
- `WE3`  in  1  write enable.
- `RSV`  in  1  reserve: mark register `RA` busy (a producer was issued).
- `RA`  in  AW  reserve address.
- `BUSY_CNT`  out  AW+1  number of registers currently busy.

## Operation
- Storage: `NREG` registers of `WIDTH` bits, plus one busy bit per register.
- Register 0 always reads 0 and is never busy.
  - A write to address 0 is ignored.
  - A reserve of address 0 is ignored and does not change `BUSY_CNT`.
- Write: if `WE3` and `A3 != 0`, then `reg[A3] <= WD3` and `busy[A3] <= 0`.
- Reserve: if `RSV` and `RA != 0`, then `busy[RA] <= 1`.
- Simultaneous write and reserve to the same nonzero address:
  - Data is written.
  - The busy bit ends at 1, because the new producer is younger.
- Writing a register that is not busy is legal: data updates and busy stays 0.
- Reserving a register that is already busy is legal: busy stays 1 and the count is unchanged.
- `BUSY_CNT` is a registered counter that always equals the popcount of the busy bits. Its per-cycle delta is the sum of:
  - +1 if a reserve sets a bit that was 0.
  - −1 if a write clears a bit that was 1 and the same edge does not re-reserve it.
  - Delta is therefore −1, 0 or +1.
- Reads are combinational from stored state: `RD1 = reg[A1]` and `BUSY1 = busy[A1]`. Port 2 behaves the same with `A2`.

## Timing
- Reset, asynchronous and immediate:
  - All registers are cleared to 0.
  - All busy bits are cleared to 0.
  - `BUSY_CNT` = 0.
  - Therefore `RD1`/`RD2` = 0 and `BUSY1`/`BUSY2` = 0.
- Reset asserted mid-operation discards every reservation and any write on that edge. The first write or reserve takes effect on the first rising edge after `rst` deasserts.
- Read latency is 0 cycles (combinational).
- Write and reserve take effect at the rising edge. Without bypass, they are visible on the read ports from the following cycle.
- `BUSY_CNT` reflects the state after the last edge. It is never bypassed.

## Configuration
- `REGFILE_BYPASS_EN` defined: when `WE3` is high and `A3 != 0`:
  - A read port whose address equals `A3` returns `WD3` in the same cycle.
  - That port's busy output is 0.
  - This also holds when `RSV` targets the same address that cycle. The reader is older than the new producer.
- `REGFILE_BYPASS_EN` undefined: reads come strictly from stored state, and a same-cycle write becomes visible one cycle later.

## Test plan
- Reset, then read all 32 addresses -> every `RD` = 0, every `BUSY` = 0, `BUSY_CNT` = 0.
- `RSV` on `RA=5`, next cycle `A1=5` -> `BUSY1` = 1, `BUSY_CNT` = 1. Then `WE3`, `A3=5`, `WD3=0xDEADBEEF` -> after the edge `RD1` = 0xDEADBEEF, `BUSY1` = 0, `BUSY_CNT` = 0.
- Same-cycle bypass: `WE3`, `A3=7`, `WD3=0x1234`, `A2=7`, with reg7 = 0 and busy:
  - With `REGFILE_BYPASS_EN`: `RD2` = 0x1234 and `BUSY2` = 0 in that cycle.
  - Without it: `RD2` = 0 and `BUSY2` = 1 in that cycle, then 0x1234 and 0 the next cycle.
- Write and reserve of reg 9 on the same edge while reg 9 is busy with `BUSY_CNT` = 1 -> reg9 = `WD3`, `BUSY` stays 1, `BUSY_CNT` stays 1.
- Register 0: `WE3` with `A3=0`, `WD3=0xFFFFFFFF`, plus `RSV` with `RA=0` -> `RD1` at `A1=0` = 0, `BUSY1` = 0, `BUSY_CNT` unchanged.
- Reserve regs 1–31 -> `BUSY_CNT` = 31. Assert `rst` between edges -> `BUSY_CNT` = 0 and all busy bits = 0 immediately, without waiting for a clock edge.
